cp0_unit: RTL
=============

// Module: cp0_unit
// PURPOSE
//  Coprocessor 0 for the P7 pipeline. Sits in the M stage and supplies the
//  exception/interrupt request (req) and the return address (epc_out) that the
//  fetch-side PC logic consumes. Holds SR, Cause, EPC and PRId, serves mfc0/mtc0,
//  latches exception state on req and clears EXL on eret.
// PARAMETERS
//  SR_ADDR     5'd12         register index of SR
//  CAUSE_ADDR  5'd13         register index of Cause
//  EPC_ADDR    5'd14         register index of EPC
//  PRID_VALUE  32'h2023_0707 constant read from index 15
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  reset        in   1   synchronous, active-high reset
//  we           in   1   mtc0 write enable (M stage)
//  cp0_addr     in   5   mfc0/mtc0 register index
//  cp0_wdata    in   32  mtc0 write data
//  cp0_rdata    out  32  mfc0 read data, combinational
//  vpc          in   32  PC of the instruction currently in M
//  bd_in        in   1   M-stage instruction sits in a branch delay slot
//  exc_code_in  in   5   pipelined exception code of M instruction; 0 = none
//  hw_int       in   6   external interrupt lines, level-sensitive
//  exl_clr      in   1   eret in M: clear EXL
//  epc_out      out  32  EPC value for eret redirect
//  req          out  1   take exception/interrupt this cycle
// BEHAVIOUR
//  - Fields: SR.IM=[15:10], SR.EXL=[1], SR.IE=[0]; Cause.BD=[31], Cause.IP=[15:10],
//    Cause.ExcCode=[6:2]; all other bits are held 0 and read 0.
//  - Reset: SR, Cause, EPC = 0; req = 0 while reset is high regardless of inputs.
//  - int_req = |(hw_int & SR.IM) & SR.IE & !SR.EXL.
//  - exc_req = (exc_code_in != 0) & !SR.EXL. req = int_req | exc_req (combinational).
//  - Interrupt beats exception: on int_req, ExcCode <= 0 even if exc_code_in != 0.
//  - Cause.IP <= hw_int every cycle, independent of req and EXL.
//  - Posedge with req: EXL <= 1; ExcCode as above; BD <= bd_in;
//    EPC <= bd_in ? vpc - 4 : vpc (32-bit wrap, no alignment forcing).
//  - Priority per cycle: reset > req > exl_clr > mtc0 write. The mtc0 write and
//    exl_clr are dropped in a cycle with req (victim instruction does not commit).
//  - exl_clr without req: EXL <= 0 next edge; IM/IE unchanged.
//  - mtc0 (we & !req): SR_ADDR writes IM/EXL/IE fields only; EPC_ADDR writes all
//    32 bits; CAUSE_ADDR, 15 and any other index are ignored (Cause read-only).
//  - mtc0 to SR_ADDR and exl_clr same cycle: write data wins for EXL.
//  - cp0_rdata: SR/Cause/EPC by index, PRID_VALUE at 15, 0 otherwise; shows the
//    current register value, not the same-cycle write.
//  - epc_out = (we & cp0_addr==EPC_ADDR) ? cp0_wdata : EPC (mtc0->eret bypass).
//  - While EXL=1 no further req fires; hw_int changes are still reflected in IP.
//  - Latency: req same cycle as cause; new state visible on cp0_rdata 1 cycle later.
// TESTING
//  1 reset=1, exc_code_in=4 -> req=0; after reset SR=Cause=EPC=0, read idx15=PRID_VALUE.
//  2 exc_code_in=10, vpc=0x3010, bd_in=1, EXL=0 -> req=1; next cycle EPC=0x300C,
//    Cause.BD=1, ExcCode=10, EXL=1; repeat exc while EXL=1 -> req=0.
//  3 mtc0 SR=0x0000_0401 (IM[10], IE), hw_int=6'b000001 -> req=1, ExcCode=0,
//    EPC=vpc; same-cycle exc_code_in=12 still yields ExcCode=0.
//  4 eret: exl_clr=1 with EXL=1 -> EXL=0 next cycle; pending unmasked hw_int
//    then raises req the following cycle.
//  5 mtc0 EPC=0x4000 with same-cycle read of epc_out -> 0x4000; mtc0 Cause=0xFFFFFFFF
//    -> Cause unchanged; mtc0 coincident with req -> write dropped.
//  6 hw_int toggles with IM=0 -> req=0, Cause.IP tracks hw_int one cycle later.

Source files
------------

// File: rtl/cp0_unit_if.sv
// rtl/cp0_unit_if.sv - mfc0/mtc0 register access bus for cp0_unit
interface cp0_unit_if;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;

  modport master (output we, output cp0_addr, output cp0_wdata, input cp0_rdata);
  modport slave  (input we, input cp0_addr, input cp0_wdata, output cp0_rdata);
endinterface

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - coprocessor 0: SR/Cause/EPC/PRId, exception and interrupt request
module cp0_unit #(
  parameter logic [4:0]  SR_ADDR    = 5'd12,
  parameter logic [4:0]  CAUSE_ADDR = 5'd13,
  parameter logic [4:0]  EPC_ADDR   = 5'd14,
  parameter logic [31:0] PRID_VALUE = 32'h2023_0707
) (
  input  logic        clk,
  input  logic        reset,
  cp0_unit_if.slave   bus,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic [31:0] epc_out,
  output logic        req
);

  localparam logic [4:0] PRID_ADDR = 5'd15;

  // SR fields
  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  // Cause fields
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc_code;
  // EPC
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign sr_val    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
  assign cause_val = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc_code, 2'b0};

  assign wr_sr  = bus.we && (bus.cp0_addr == SR_ADDR);
  assign wr_epc = bus.we && (bus.cp0_addr == EPC_ADDR);

  // Request generation; the reset gate keeps req low while the pipeline is held in reset
  always_comb begin
    int_req = (|(hw_int & sr_im)) && sr_ie && !sr_exl;
    exc_req = (exc_code_in != 5'd0) && !sr_exl;
    req     = !reset && (int_req || exc_req);
  end

  // mfc0 read mux shows registered state only; epc_out bypasses a same-cycle EPC write for eret
  always_comb begin
    bus.cp0_rdata = 32'b0;
    case (bus.cp0_addr)
      SR_ADDR:    bus.cp0_rdata = sr_val;
      CAUSE_ADDR: bus.cp0_rdata = cause_val;
      EPC_ADDR:   bus.cp0_rdata = epc;
      PRID_ADDR:  bus.cp0_rdata = PRID_VALUE;
      default:    bus.cp0_rdata = 32'b0;
    endcase
    epc_out = wr_epc ? bus.cp0_wdata : epc;
  end

  // Register update: reset > req > eret > mtc0; the victim's mtc0/eret are dropped on req
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im          <= 6'b0;
      sr_exl         <= 1'b0;
      sr_ie          <= 1'b0;
      cause_bd       <= 1'b0;
      cause_ip       <= 6'b0;
      cause_exc_code <= 5'b0;
      epc            <= 32'b0;
    end else begin
      cause_ip <= hw_int;
      if (req) begin
        sr_exl         <= 1'b1;
        cause_exc_code <= int_req ? 5'd0 : exc_code_in;
        cause_bd       <= bd_in;
        epc            <= bd_in ? (vpc - 32'd4) : vpc;
      end else begin
        if (exl_clr) begin
          sr_exl <= 1'b0;
        end
        // Placed after eret so an mtc0 to SR in the same cycle decides EXL
        if (wr_sr) begin
          sr_im  <= bus.cp0_wdata[15:10];
          sr_exl <= bus.cp0_wdata[1];
          sr_ie  <= bus.cp0_wdata[0];
        end
        if (wr_epc) begin
          epc <= bus.cp0_wdata;
        end
      end
    end
  end

endmodule
